// File: rtl/wimpfi_rcvr_adapter.sv
// WimpFi receive adapter: buffers one frame from mx_rcvr, filters on address,
// checks type/CRC-8 and streams accepted payload bytes to the UART transmitter.
module wimpfi_rcvr_adapter #(
   parameter int unsigned MAX_LEN    = 255,
   parameter logic [7:0]  BCAST_ADDR = 8'h2A
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] my_addr,
   input  logic       cardet,
   input  logic       rvalid,
   input  logic [7:0] rdata,
   input  logic       rerr,
   input  logic       urdy,
   output logic [7:0] udata,
   output logic       uvalid,
   output logic       frame_ok,
   output logic       ack_rcvd,
   output logic [7:0] ack_src,
   output logic [7:0] rx_src,
   output logic [7:0] rx_type,
   output logic [7:0] rerrcnt,
   output logic       busy
);

   localparam int unsigned   LW        = $clog2(MAX_LEN + 1);
   localparam logic [LW-1:0] LEN_MAX   = LW'(MAX_LEN);
   localparam logic [7:0]    TYPE_DATA = 8'h30;
   localparam logic [7:0]    TYPE_FCS  = 8'h31;
   localparam logic [7:0]    TYPE_ACK  = 8'h32;

   typedef enum logic [1:0] {IDLE, RECV, CHECK, DRAIN} state_t;

   state_t          state_q, state_d;
   logic [LW-1:0]   len_q, len_d;
   logic [LW-1:0]   rd_q, rd_d;
   logic [LW-1:0]   end_q, end_d;
   logic [7:0]      crc_q, crc_d;
   logic            err_q, err_d;
   logic            ovf_q, ovf_d;
   logic            drop_q, drop_d;
   logic [7:0]      ack_src_q, ack_src_d;
   logic [7:0]      rx_src_q, rx_src_d;
   logic [7:0]      rx_type_q, rx_type_d;
   logic [7:0]      rerrcnt_q, rerrcnt_d;

   logic [7:0]      mem_q [MAX_LEN];
   logic            wr_en;
   logic [LW-1:0]   wr_idx;
   logic            cnt_inc;
   logic [7:0]      dest, ftype;
   logic [LW-1:0]   data_end;

   function automatic logic [7:0] crc8_upd(input logic [7:0] crc, input logic [7:0] data);
      logic [7:0] c;
      c = crc ^ data;
      for (int unsigned i = 0; i < 8; i++) begin
         c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
      end
      return c;
   endfunction

   assign dest     = mem_q[0];
   assign ftype    = mem_q[2];
   assign data_end = (ftype == TYPE_FCS) ? len_q - LW'(1) : len_q;

   always_comb begin
      state_d   = state_q;
      len_d     = len_q;
      rd_d      = rd_q;
      end_d     = end_q;
      crc_d     = crc_q;
      err_d     = err_q;
      ovf_d     = ovf_q;
      drop_d    = drop_q;
      ack_src_d = ack_src_q;
      rx_src_d  = rx_src_q;
      rx_type_d = rx_type_q;
      wr_en     = 1'b0;
      wr_idx    = len_q;
      cnt_inc   = 1'b0;
      frame_ok  = 1'b0;
      ack_rcvd  = 1'b0;

      case (state_q)
         IDLE: begin
            // drop_q blocks the tail of a frame that began while draining
            if (rvalid && cardet && !drop_q) begin
               wr_en   = 1'b1;
               wr_idx  = '0;
               len_d   = LW'(1);
               crc_d   = crc8_upd('0, rdata);
               err_d   = 1'b0;
               ovf_d   = 1'b0;
               state_d = RECV;
            end
         end
         RECV: begin
            if (rvalid) begin
               if (len_q == LEN_MAX) begin
                  ovf_d = 1'b1;
               end else begin
                  wr_en = 1'b1;
                  len_d = len_q + LW'(1);
                  crc_d = crc8_upd(crc_q, rdata);
               end
            end
            if (rerr) err_d = 1'b1;
            if (!cardet) state_d = CHECK;
         end
         CHECK: begin
            state_d = IDLE;
            if (err_q || ovf_q) begin
               cnt_inc = 1'b1;
            end else if (len_q < LW'(3)) begin
               cnt_inc = 1'b1;
            end else if (dest != my_addr && dest != BCAST_ADDR) begin
               cnt_inc = 1'b0;
            end else if (ftype == TYPE_FCS && (len_q < LW'(4) || crc_q != 8'h00)) begin
               cnt_inc = 1'b1;
            end else if (ftype == TYPE_ACK && len_q != LW'(3)) begin
               cnt_inc = 1'b1;
            end else if (ftype != TYPE_DATA && ftype != TYPE_FCS && ftype != TYPE_ACK) begin
               cnt_inc = 1'b1;
            end else begin
               frame_ok  = 1'b1;
               rx_src_d  = mem_q[1];
               rx_type_d = ftype;
               if (ftype == TYPE_ACK) begin
                  ack_rcvd  = 1'b1;
                  ack_src_d = mem_q[1];
               end else if (data_end > LW'(3)) begin
                  rd_d    = LW'(3);
                  end_d   = data_end;
                  state_d = DRAIN;
               end
            end
         end
         DRAIN: begin
            if (urdy) begin
               if (rd_q == end_q - LW'(1)) state_d = IDLE;
               else rd_d = rd_q + LW'(1);
            end
         end
         default: state_d = IDLE;
      endcase

      if (state_q == DRAIN && cardet) drop_d = 1'b1;
      if (drop_q && !cardet) begin
         drop_d  = 1'b0;
         cnt_inc = 1'b1;
      end
   end

   assign rerrcnt_d = (cnt_inc && rerrcnt_q != 8'hFF) ? rerrcnt_q + 8'd1 : rerrcnt_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         len_q     <= '0;
         rd_q      <= '0;
         end_q     <= '0;
         crc_q     <= '0;
         err_q     <= 1'b0;
         ovf_q     <= 1'b0;
         drop_q    <= 1'b0;
         ack_src_q <= '0;
         rx_src_q  <= '0;
         rx_type_q <= '0;
         rerrcnt_q <= '0;
      end else begin
         state_q   <= state_d;
         len_q     <= len_d;
         rd_q      <= rd_d;
         end_q     <= end_d;
         crc_q     <= crc_d;
         err_q     <= err_d;
         ovf_q     <= ovf_d;
         drop_q    <= drop_d;
         ack_src_q <= ack_src_d;
         rx_src_q  <= rx_src_d;
         rx_type_q <= rx_type_d;
         rerrcnt_q <= rerrcnt_d;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) mem_q[wr_idx] <= rdata;
   end

   assign uvalid  = (state_q == DRAIN);
   assign udata   = uvalid ? mem_q[rd_q] : '0;
   assign busy    = (state_q != IDLE);
   assign ack_src = ack_src_q;
   assign rx_src  = rx_src_q;
   assign rx_type = rx_type_q;
   assign rerrcnt = rerrcnt_q;

endmodule

// File: tb/tb_wimpfi_rcvr_adapter.sv
// Directed self-checking bench for wimpfi_rcvr_adapter.
module tb_wimpfi_rcvr_adapter;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] my_addr;
   logic       cardet;
   logic       rvalid;
   logic [7:0] rdata;
   logic       rerr;
   logic       urdy;
   logic [7:0] udata;
   logic       uvalid;
   logic       frame_ok;
   logic       ack_rcvd;
   logic [7:0] ack_src;
   logic [7:0] rx_src;
   logic [7:0] rx_type;
   logic [7:0] rerrcnt;
   logic       busy;

   int         n_cmp = 0;
   int         n_bad = 0;
   logic [7:0] got_q[$];
   bit         timed_out;

   wimpfi_rcvr_adapter #(.MAX_LEN(255), .BCAST_ADDR(8'h2A)) dut (
      .clk(clk), .rst(rst), .my_addr(my_addr), .cardet(cardet),
      .rvalid(rvalid), .rdata(rdata), .rerr(rerr), .urdy(urdy),
      .udata(udata), .uvalid(uvalid), .frame_ok(frame_ok),
      .ack_rcvd(ack_rcvd), .ack_src(ack_src), .rx_src(rx_src),
      .rx_type(rx_type), .rerrcnt(rerrcnt), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [7:0] crc_model(input logic [7:0] b[$]);
      logic [7:0] crc;
      logic       fb;
      crc = 8'h00;
      foreach (b[i]) begin
         for (int j = 7; j >= 0; j--) begin
            fb  = crc[7] ^ b[i][j];
            crc = {crc[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
         end
      end
      return crc;
   endfunction

   // Sends all bytes back to back, drops cardet; returns with the DUT in CHECK.
   task automatic send_frame(input logic [7:0] b[$], input int rerr_at);
      cardet = 1'b1;
      foreach (b[i]) begin
         rvalid = 1'b1;
         rdata  = b[i];
         rerr   = (i == rerr_at);
         tick();
      end
      rvalid = 1'b0;
      rerr   = 1'b0;
      cardet = 1'b0;
      tick();
   endtask

   // Accepts bytes until busy falls (bounded); toggle stalls every other cycle.
   task automatic collect(input bit toggle);
      int cyc;
      got_q.delete();
      cyc = 0;
      while (busy && cyc < 200) begin
         urdy = toggle ? cyc[0] : 1'b1;
         if (uvalid && urdy) got_q.push_back(udata);
         tick();
         cyc++;
      end
      urdy      = 1'b0;
      timed_out = busy;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      n_cmp++; if (uvalid !== 1'b0) begin n_bad++; $display("FAIL reset_uvalid got %b want 0", uvalid); end
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", busy); end
      n_cmp++; if (rerrcnt !== 8'h00) begin n_bad++; $display("FAIL reset_rerrcnt got %h want 00", rerrcnt); end
      n_cmp++; if (frame_ok !== 1'b0) begin n_bad++; $display("FAIL reset_frame_ok got %b want 0", frame_ok); end
      n_cmp++; if (rx_src !== 8'h00) begin n_bad++; $display("FAIL reset_rx_src got %h want 00", rx_src); end
      n_cmp++; if (udata !== 8'h00) begin n_bad++; $display("FAIL reset_udata got %h want 00", udata); end
   endtask

   task automatic test_reset_mid_drain();
      send_frame('{8'h42, 8'h17, 8'h30, 8'h41, 8'h42}, -1);
      urdy = 1'b0;
      tick();
      n_cmp++; if (uvalid !== 1'b1) begin n_bad++; $display("FAIL rstdrain_pre_uvalid got %b want 1", uvalid); end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      n_cmp++; if (uvalid !== 1'b0) begin n_bad++; $display("FAIL rstdrain_uvalid got %b want 0", uvalid); end
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rstdrain_busy got %b want 0", busy); end
      n_cmp++; if (rerrcnt !== 8'h00) begin n_bad++; $display("FAIL rstdrain_rerrcnt got %h want 00", rerrcnt); end
      n_cmp++; if (rx_src !== 8'h00) begin n_bad++; $display("FAIL rstdrain_rx_src got %h want 00", rx_src); end
      tick();
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rstdrain_stay_idle got %b want 0", busy); end
   endtask

   task automatic test_data_frame();
      logic [7:0] exp[$];
      exp = '{8'h48, 8'h69};
      send_frame('{8'h42, 8'h17, 8'h30, 8'h48, 8'h69}, -1);
      n_cmp++; if (frame_ok !== 1'b1) begin n_bad++; $display("FAIL data_frame_ok got %b want 1", frame_ok); end
      n_cmp++; if (uvalid !== 1'b0) begin n_bad++; $display("FAIL data_uvalid_in_check got %b want 0", uvalid); end
      tick();
      n_cmp++; if (rx_src !== 8'h17) begin n_bad++; $display("FAIL data_rx_src got %h want 17", rx_src); end
      n_cmp++; if (rx_type !== 8'h30) begin n_bad++; $display("FAIL data_rx_type got %h want 30", rx_type); end
      n_cmp++; if (uvalid !== 1'b1) begin n_bad++; $display("FAIL data_first_uvalid got %b want 1", uvalid); end
      collect(1'b1);
      n_cmp++; if (timed_out) begin n_bad++; $display("FAIL data_timeout got busy=1 want busy=0"); end
      n_cmp++; if (got_q.size() != exp.size()) begin n_bad++; $display("FAIL data_count got %0d want %0d", got_q.size(), exp.size()); end
      foreach (exp[i]) begin
         n_cmp++;
         if (i >= got_q.size() || got_q[i] !== exp[i]) begin
            n_bad++; $display("FAIL data_byte%0d got %h want %h", i, (i < got_q.size()) ? got_q[i] : 8'hxx, exp[i]);
         end
      end
      n_cmp++; if (busy !== 1'b0 || uvalid !== 1'b0) begin n_bad++; $display("FAIL data_end got busy=%b uvalid=%b want 0/0", busy, uvalid); end
   endtask

   task automatic test_fcs();
      logic [7:0] fr[$];
      logic [7:0] fcs;
      logic [7:0] exp[$];
      exp = '{8'h01, 8'h02, 8'h03};
      fr  = '{8'h2A, 8'h05, 8'h31, 8'h01, 8'h02, 8'h03};
      fcs = crc_model(fr);
      fr.push_back(fcs);
      send_frame(fr, -1);
      n_cmp++; if (frame_ok !== 1'b1) begin n_bad++; $display("FAIL fcs_good_ok got %b want 1", frame_ok); end
      tick();
      collect(1'b0);
      n_cmp++; if (timed_out) begin n_bad++; $display("FAIL fcs_timeout got busy=1 want busy=0"); end
      n_cmp++; if (got_q.size() != 3) begin n_bad++; $display("FAIL fcs_count got %0d want 3", got_q.size()); end
      foreach (exp[i]) begin
         n_cmp++;
         if (i >= got_q.size() || got_q[i] !== exp[i]) begin
            n_bad++; $display("FAIL fcs_byte%0d got %h want %h", i, (i < got_q.size()) ? got_q[i] : 8'hxx, exp[i]);
         end
      end
      n_cmp++; if (rerrcnt !== 8'h00) begin n_bad++; $display("FAIL fcs_good_rerrcnt got %h want 00", rerrcnt); end
      fr[6] = fcs ^ 8'h01;
      send_frame(fr, -1);
      n_cmp++; if (frame_ok !== 1'b0) begin n_bad++; $display("FAIL fcs_bad_ok got %b want 0", frame_ok); end
      tick();
      n_cmp++; if (uvalid !== 1'b0) begin n_bad++; $display("FAIL fcs_bad_uvalid got %b want 0", uvalid); end
      n_cmp++; if (rerrcnt !== 8'h01) begin n_bad++; $display("FAIL fcs_bad_rerrcnt got %h want 01", rerrcnt); end
   endtask

   task automatic test_filter();
      send_frame('{8'h99, 8'h17, 8'h30, 8'h41}, -1);
      n_cmp++; if (frame_ok !== 1'b0) begin n_bad++; $display("FAIL filter_ok got %b want 0", frame_ok); end
      tick();
      n_cmp++; if (uvalid !== 1'b0) begin n_bad++; $display("FAIL filter_uvalid got %b want 0", uvalid); end
      n_cmp++; if (rerrcnt !== 8'h01) begin n_bad++; $display("FAIL filter_rerrcnt got %h want 01", rerrcnt); end
      send_frame('{8'h42, 8'h17, 8'h32}, -1);
      n_cmp++; if (ack_rcvd !== 1'b1) begin n_bad++; $display("FAIL ack_pulse got %b want 1", ack_rcvd); end
      n_cmp++; if (frame_ok !== 1'b1) begin n_bad++; $display("FAIL ack_frame_ok got %b want 1", frame_ok); end
      tick();
      n_cmp++; if (ack_rcvd !== 1'b0) begin n_bad++; $display("FAIL ack_pulse_width got %b want 0", ack_rcvd); end
      n_cmp++; if (ack_src !== 8'h17) begin n_bad++; $display("FAIL ack_src got %h want 17", ack_src); end
      n_cmp++; if (rx_type !== 8'h32) begin n_bad++; $display("FAIL ack_rx_type got %h want 32", rx_type); end
      n_cmp++; if (uvalid !== 1'b0 || busy !== 1'b0) begin n_bad++; $display("FAIL ack_idle got uvalid=%b busy=%b want 0/0", uvalid, busy); end
   endtask

   task automatic test_back_to_back();
      logic [7:0] exp[$];
      exp = '{8'h41, 8'h42, 8'h43};
      send_frame('{8'h42, 8'h17, 8'h30, 8'h41, 8'h42, 8'h43}, -1);
      urdy = 1'b0;
      tick();
      tick();
      n_cmp++; if (uvalid !== 1'b1 || udata !== 8'h41) begin n_bad++; $display("FAIL b2b_stall got uvalid=%b udata=%h want 1/41", uvalid, udata); end
      cardet = 1'b1;
      for (int i = 0; i < 4; i++) begin
         rvalid = 1'b1;
         rdata  = 8'h50 + 8'(i);
         tick();
         if (frame_ok !== 1'b0) begin n_bad++; $display("FAIL b2b_drop_frame_ok got %b want 0", frame_ok); end
         n_cmp++;
      end
      rvalid = 1'b0;
      cardet = 1'b0;
      tick();
      n_cmp++; if (rerrcnt !== 8'h02) begin n_bad++; $display("FAIL b2b_rerrcnt got %h want 02", rerrcnt); end
      n_cmp++; if (uvalid !== 1'b1 || udata !== 8'h41) begin n_bad++; $display("FAIL b2b_hold got uvalid=%b udata=%h want 1/41", uvalid, udata); end
      collect(1'b0);
      n_cmp++; if (timed_out) begin n_bad++; $display("FAIL b2b_timeout got busy=1 want busy=0"); end
      n_cmp++; if (got_q.size() != 3) begin n_bad++; $display("FAIL b2b_count got %0d want 3", got_q.size()); end
      foreach (exp[i]) begin
         n_cmp++;
         if (i >= got_q.size() || got_q[i] !== exp[i]) begin
            n_bad++; $display("FAIL b2b_byte%0d got %h want %h", i, (i < got_q.size()) ? got_q[i] : 8'hxx, exp[i]);
         end
      end
      tick();
      n_cmp++; if (busy !== 1'b0 || rerrcnt !== 8'h02) begin n_bad++; $display("FAIL b2b_after got busy=%b rerrcnt=%h want 0/02", busy, rerrcnt); end
   endtask

   task automatic test_rejects();
      logic [7:0] big[$];
      send_frame('{8'h42, 8'h17, 8'h30, 8'h41}, 2);
      n_cmp++; if (frame_ok !== 1'b0) begin n_bad++; $display("FAIL rerr_ok got %b want 0", frame_ok); end
      tick();
      n_cmp++; if (rerrcnt !== 8'h03) begin n_bad++; $display("FAIL rerr_rerrcnt got %h want 03", rerrcnt); end
      send_frame('{8'h42, 8'h17}, -1);
      tick();
      n_cmp++; if (rerrcnt !== 8'h04) begin n_bad++; $display("FAIL short_rerrcnt got %h want 04", rerrcnt); end
      send_frame('{8'h42, 8'h17, 8'h35, 8'h41}, -1);
      n_cmp++; if (frame_ok !== 1'b0) begin n_bad++; $display("FAIL type35_ok got %b want 0", frame_ok); end
      tick();
      n_cmp++; if (rerrcnt !== 8'h05) begin n_bad++; $display("FAIL type35_rerrcnt got %h want 05", rerrcnt); end
      big = '{8'h42, 8'h17, 8'h30};
      for (int i = 0; i < 253; i++) big.push_back(8'(i));
      send_frame(big, -1);
      n_cmp++; if (frame_ok !== 1'b0) begin n_bad++; $display("FAIL ovf_ok got %b want 0", frame_ok); end
      tick();
      n_cmp++; if (rerrcnt !== 8'h06 || uvalid !== 1'b0) begin n_bad++; $display("FAIL ovf_rerrcnt got %h uvalid=%b want 06/0", rerrcnt, uvalid); end
      for (int i = 0; i < 249; i++) begin
         send_frame('{8'h42, 8'h17}, -1);
         tick();
      end
      n_cmp++; if (rerrcnt !== 8'hFF) begin n_bad++; $display("FAIL sat_reach got %h want ff", rerrcnt); end
      send_frame('{8'h42, 8'h17}, -1);
      tick();
      n_cmp++; if (rerrcnt !== 8'hFF) begin n_bad++; $display("FAIL sat_hold got %h want ff", rerrcnt); end
   endtask

   initial begin
      rst     = 1'b1;
      my_addr = 8'h42;
      cardet  = 1'b0;
      rvalid  = 1'b0;
      rdata   = 8'h00;
      rerr    = 1'b0;
      urdy    = 1'b0;
      test_reset();
      test_reset_mid_drain();
      test_data_frame();
      test_fcs();
      test_filter();
      test_back_to_back();
      test_rejects();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
